// File: rtl/ram_burst_reader.sv
// Burst reader: streams burst_len words from an external 1-cycle-latency RAM into a
// 2-entry output FIFO. Optional checksum output enabled with RAM_BURST_READER_CHECKSUM_EN.
module ram_burst_reader #(
  parameter int DATA  = 16,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [AW-1:0]   start_addr,
  input  logic [AW:0]     burst_len,
  output logic            busy,
  output logic            done,
  output logic            mem_rd_en,
  output logic [AW-1:0]   mem_rd_addr,
  input  logic [DATA-1:0] mem_rd_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [DATA-1:0] m_data
`ifdef RAM_BURST_READER_CHECKSUM_EN
  ,output logic [DATA-1:0] checksum
`endif
);

  // Stream handshake: a word transfers on a rising edge where m_valid && m_ready;
  // m_valid never drops and m_data never changes until that transfer happens.

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t          state;
  logic [AW:0]     issue_left;
  logic [AW:0]     out_left;
  logic            rd_pend;
  logic [DATA-1:0] fifo_mem [2];
  logic            rd_ptr;
  logic            wr_ptr;
  logic [1:0]      count;
  logic            pop;
  logic            push;
  logic            start_accept;
  logic [AW:0]     len_sat;
  logic [AW-1:0]   addr_inc;
  logic [2:0]      occ;

  assign m_valid      = (count != 2'd0);
  assign m_data       = fifo_mem[rd_ptr];
  assign pop          = m_valid & m_ready;
  assign push         = rd_pend;
  assign start_accept = (state == IDLE) && start && (burst_len != '0);
  assign len_sat      = (burst_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : burst_len;
  assign addr_inc     = (mem_rd_addr == AW'(DEPTH - 1)) ? '0 : mem_rd_addr + AW'(1);

  // Words buffered or still on their way back, less the one leaving this cycle;
  // a new strobe is allowed only if it is sure to find a free FIFO slot.
  assign occ       = {1'b0, count} + {2'b00, rd_pend} - {2'b00, pop};
  assign mem_rd_en = (state == READ) && (occ < 3'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      issue_left  <= '0;
      out_left    <= '0;
      rd_pend     <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd_addr <= '0;
    end else begin
      done    <= 1'b0;
      rd_pend <= mem_rd_en;
      if (push) begin
        fifo_mem[wr_ptr] <= mem_rd_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr   <= ~rd_ptr;
        out_left <= out_left - (AW+1)'(1);
      end
      count <= count + 2'(push) - 2'(pop);

      case (state)
        IDLE: begin
          if (start_accept) begin
            mem_rd_addr <= start_addr;
            issue_left  <= len_sat;
            out_left    <= len_sat;
            busy        <= 1'b1;
            state       <= READ;
          end
        end
        READ: begin
          if (mem_rd_en) begin
            mem_rd_addr <= addr_inc;
            issue_left  <= issue_left - (AW+1)'(1);
            if (issue_left == (AW+1)'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && out_left == (AW+1)'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RAM_BURST_READER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || start_accept) checksum <= '0;
    else if (pop)              checksum <= checksum + m_data;
  end
`endif

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader: RAM model, negedge monitor with scoreboard,
// and hand-computed expectations for each burst scenario.
module tb_ram_burst_reader;

  localparam int DATA  = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [AW-1:0]   start_addr;
  logic [AW:0]     burst_len;
  logic            busy;
  logic            done;
  logic            mem_rd_en;
  logic [AW-1:0]   mem_rd_addr;
  logic [DATA-1:0] mem_rd_data = '0;
  logic            m_valid;
  logic            m_ready;
  logic [DATA-1:0] m_data;
`ifdef RAM_BURST_READER_CHECKSUM_EN
  logic [DATA-1:0] checksum;
`endif

  ram_burst_reader #(.DATA(DATA), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .burst_len(burst_len), .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data)
`ifdef RAM_BURST_READER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // external RAM: data one cycle after the strobe
  logic [DATA-1:0] ram [DEPTH];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];

  // scoreboard
  logic [DATA-1:0] exp_q[$];
  logic [AW-1:0]   addr_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int rd_en_cnt, done_cnt, hs_cnt, first_hs, last_hs;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_rd_en) begin
        rd_en_cnt++;
        addr_q.push_back(mem_rd_addr);
      end
      if (done) done_cnt++;
      if (m_valid && m_ready) begin
        hs_cnt++;
        if (hs_cnt == 1) first_hs = cyc;
        last_hs = cyc;
        if (exp_q.size() != 0) check("word", 32'(m_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks
  task automatic clear_stats();
    rd_en_cnt = 0; done_cnt = 0; hs_cnt = 0; first_hs = 0; last_hs = 0;
    addr_q.delete();
  endtask

  task automatic load_exp(input int a, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(ram[(a + i) % DEPTH]);
  endtask

  // called just after a rising edge; returns just after the edge that samples start
  task automatic start_burst(input int a, input int n);
    start      = 1'b1;
    start_addr = AW'(a);
    burst_len  = (AW+1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int g = 0;
    while (!done && g < max_cyc) begin
      @(negedge clk);
      g++;
    end
    if (!done) check("done_timeout", 32'(g), 32'(max_cyc + 1));
    @(posedge clk); #1;
  endtask

  task automatic wait_hs(input int n);
    int g = 0;
    while (hs_cnt < n && g < 100) begin
      @(posedge clk);
      g++;
    end
    if (hs_cnt < n) check("hs_timeout", 32'(hs_cnt), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = DATA'(16'h0100 + i);
    reset = 1'b1; start = 1'b0; start_addr = '0; burst_len = '0; m_ready = 1'b1;
    clear_stats();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_busy",    32'(busy),        0);
    check("rst_done",    32'(done),        0);
    check("rst_rd_en",   32'(mem_rd_en),   0);
    check("rst_rd_addr", 32'(mem_rd_addr), 0);
    check("rst_valid",   32'(m_valid),     0);
    check("rst_data",    32'(m_data),      0);

    // addr 0 len 4, with latency checks
    @(posedge clk); #1;
    clear_stats(); load_exp(0, 4);
    start_burst(0, 4);
    @(negedge clk);
    check("lat_busy",   32'(busy),      1);
    check("lat_rd_en",  32'(mem_rd_en), 1);
    check("lat_valid0", 32'(m_valid),   0);
    @(negedge clk);
    check("lat_valid1", 32'(m_valid),   0);
    @(negedge clk);
    check("lat_valid2", 32'(m_valid),   1);
    check("lat_data2",  32'(m_data),    32'h0100);
    wait_done(40);
    check("b4_words",  32'(hs_cnt),            4);
    check("b4_consec", 32'(last_hs - first_hs), 3);
    check("b4_rd_en",  32'(rd_en_cnt),         4);
    check("b4_done",   32'(done_cnt),          1);
    check("b4_busy",   32'(busy),              0);

    // wrap: addr 14 len 4
    clear_stats(); load_exp(14, 4);
    start_burst(14, 4);
    wait_done(40);
    check("wr_words", 32'(hs_cnt), 4);
    check("wr_addr0", 32'(addr_q[0]), 14);
    check("wr_addr1", 32'(addr_q[1]), 15);
    check("wr_addr2", 32'(addr_q[2]), 0);
    check("wr_addr3", 32'(addr_q[3]), 1);

    // len 8 with back-pressure after word 2
    clear_stats(); load_exp(0, 8);
    start_burst(0, 8);
    wait_hs(2);
    #1 m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) begin
        check("bp_rd_en", 32'(mem_rd_en), 0);
        check("bp_valid", 32'(m_valid),   1);
        check("bp_hold",  32'(m_data),    32'h0102);
      end
    end
    @(posedge clk); #1 m_ready = 1'b1;
    wait_done(60);
    check("bp_words", 32'(hs_cnt),      8);
    check("bp_rd_en_total", 32'(rd_en_cnt), 8);
    check("bp_done",  32'(done_cnt),    1);
    check("bp_sb_left", 32'(exp_q.size()), 0);

    // start while busy is ignored
    clear_stats(); load_exp(0, 4);
    start_burst(0, 4);
    start = 1'b1; start_addr = AW'(8); burst_len = (AW+1)'(4);
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    wait_done(40);
    repeat (6) @(posedge clk);
    #1;
    check("sb_words", 32'(hs_cnt),    4);
    check("sb_rd_en", 32'(rd_en_cnt), 4);
    check("sb_done",  32'(done_cnt),  1);

    // burst_len 0 in IDLE is ignored
    clear_stats();
    start_burst(5, 0);
    repeat (5) @(negedge clk);
    check("z_busy",  32'(busy),      0);
    check("z_rd_en", 32'(rd_en_cnt), 0);
    check("z_done",  32'(done_cnt),  0);

    // reset during 3rd beat of a len-8 burst
    @(posedge clk); #1;
    clear_stats(); load_exp(0, 8);
    start_burst(0, 8);
    wait_hs(2);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("mr_busy",    32'(busy),        0);
    check("mr_done",    32'(done),        0);
    check("mr_rd_en",   32'(mem_rd_en),   0);
    check("mr_rd_addr", 32'(mem_rd_addr), 0);
    check("mr_valid",   32'(m_valid),     0);
    check("mr_data",    32'(m_data),      0);
    exp_q.delete();
    repeat (10) @(posedge clk);
    #1;
    check("mr_no_done", 32'(done_cnt), 0);
    check("mr_no_hs",   32'(hs_cnt),   2);
    clear_stats(); load_exp(3, 2);
    start_burst(3, 2);
    wait_done(40);
    check("mr_next_words", 32'(hs_cnt),   2);
    check("mr_next_done",  32'(done_cnt), 1);

    // len 20 saturates to DEPTH, mem[i] = i
    for (int i = 0; i < DEPTH; i++) ram[i] = DATA'(i);
    clear_stats(); load_exp(0, 16);
    start_burst(0, 20);
`ifdef RAM_BURST_READER_CHECKSUM_EN
    check("ck_clear", 32'(checksum), 0);
`endif
    begin
      int g = 0;
      while (!done && g < 80) begin
        @(negedge clk);
        g++;
      end
      check("sat_done_seen", 32'(done), 1);
`ifdef RAM_BURST_READER_CHECKSUM_EN
      check("ck_at_done", 32'(checksum), 32'h0078);
`endif
    end
    repeat (4) @(posedge clk);
    #1;
    check("sat_words", 32'(hs_cnt),    16);
    check("sat_rd_en", 32'(rd_en_cnt), 16);
    check("sat_done",  32'(done_cnt),  1);
`ifdef RAM_BURST_READER_CHECKSUM_EN
    check("ck_hold", 32'(checksum), 32'h0078);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
